// File: rtl/dm_wait_ctrl.sv
// dm_wait_ctrl: MEM-stage data-memory controller with programmable wait states.
// A request is latched in IDLE, held in WAIT for WAIT_CYCLES extra cycles, and
// completes with a one-cycle ack in DONE. Loads return the full aligned word;
// the downstream extension stage picks the byte/half and extends it.
//
// state | meaning
// IDLE  | no access in flight; latch request and check for address errors
// WAIT  | wait-state countdown; access fires on the edge leaving WAIT
// DONE  | ack (and adel/ades on error) for exactly one cycle
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   req, we, size     access request, 1=store, 00 word/01 half/10 byte/11 word
//   addr, wdata       byte address, right-aligned store data
//   rdata             aligned word read (holds until next successful load)
//   ack, stall        completion pulse, pipeline freeze (req & ~ack)
//   byte_en           lane enables of the store in flight
//   adel, ades        load/store address error, valid with ack
module dm_wait_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall,
  output logic [3:0]  byte_en,
  output logic        adel,
  output logic        ades
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wword_q;
  logic                  err_q;
  logic [3:0]            lane_en;
  logic                  misalign;
  logic                  out_of_range;
  logic                  access_fire;

  logic [31:0] mem [2**ADDR_WIDTH];

  // size 11 falls through to word handling everywhere
  always_comb begin
    misalign = 1'b0;
    unique case (size)
      2'b01:   misalign = addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end

  assign out_of_range = ((addr >> (ADDR_WIDTH + 2)) != 32'd0);

  always_comb begin
    lane_en = 4'b1111;
    unique case (size_q)
      2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_en = 4'b0001 << addr_q[1:0];
      default: lane_en = 4'b1111;
    endcase
  end

  // A drop of req on the final countdown edge still counts as an abort
  assign access_fire = (state_q == S_WAIT) && req && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = (misalign || out_of_range) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (!req)              state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wword_q <= 32'd0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        we_q   <= we;
        size_q <= size;
        addr_q <= addr[ADDR_WIDTH+1:0];
        err_q  <= misalign || out_of_range;
        cnt_q  <= 4'(WAIT_CYCLES);
        unique case (size)
          2'b01:   wword_q <= {2{wdata[15:0]}};
          2'b10:   wword_q <= {4{wdata[7:0]}};
          default: wword_q <= wdata;
        endcase
      end else if (state_q == S_WAIT && req && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access_fire && !we_q) rdata <= mem[addr_q[ADDR_WIDTH+1:2]];
    end
  end

  // Memory has no reset; a reset mid-access forces IDLE so no write fires
  always_ff @(posedge clk) begin
    if (access_fire && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= wword_q[8*i +: 8];
      end
    end
  end

  assign ack     = (state_q == S_DONE);
  assign stall   = req & ~ack;
  assign adel    = ack & err_q & ~we_q;
  assign ades    = ack & err_q & we_q;
  assign byte_en = ((state_q != S_IDLE) && we_q && !err_q) ? lane_en : 4'b0000;

endmodule

// File: tb/tb_dm_wait_ctrl.sv
module tb_dm_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;
  logic [3:0]  byte_en;
  logic        adel;
  logic        ades;

  int n_chk = 0;
  int n_pass = 0;

  dm_wait_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .stall(stall), .byte_en(byte_en),
    .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk_be;
    logic [3:0]  be;
    logic        el;
    logic        es;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input int lat, input logic cb,
                     input logic [3:0] be, input logic el, input logic es,
                     input logic [31:0] rd);
    vec_t v;
    v.we = w; v.size = sz; v.addr = a; v.wdata = d; v.lat = lat; v.chk_be = cb;
    v.be = be; v.el = el; v.es = es; v.rd = rd;
    vecs.push_back(v);
  endtask

  // Drives one request, holds it until ack (bounded), then releases req.
  task automatic run_acc(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int stl,
                         output logic [3:0] be, output logic el, output logic es,
                         output logic [31:0] rd);
    lat = -1; stl = 0; be = 4'hx; el = 1'bx; es = 1'bx; rd = 32'hx;
    @(posedge clk); #1;
    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack) begin
        lat = c; be = byte_en; el = adel; es = ades; rd = rdata;
        break;
      end
      if (stall) stl++;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  int          lat, stl, acks;
  logic [3:0]  be_o;
  logic        el_o, es_o;
  logic [31:0] rd_o;

  initial begin
    //   we sz    addr          wdata         lat cb be    el es rdata
    add(1, 2'd0, 32'h10,       32'hDEADBEEF, 4, 1, 4'hF, 0, 0, 32'h0);
    add(0, 2'd0, 32'h10,       32'h0,        4, 1, 4'h0, 0, 0, 32'hDEADBEEF);
    add(1, 2'd2, 32'h13,       32'h000000AB, 4, 1, 4'h8, 0, 0, 32'hDEADBEEF);
    add(0, 2'd0, 32'h10,       32'h0,        4, 1, 4'h0, 0, 0, 32'hABADBEEF);
    add(1, 2'd1, 32'h12,       32'h00001234, 4, 1, 4'hC, 0, 0, 32'hABADBEEF);
    add(0, 2'd0, 32'h10,       32'h0,        4, 1, 4'h0, 0, 0, 32'h1234BEEF);
    add(0, 2'd0, 32'h11,       32'h0,        1, 1, 4'h0, 1, 0, 32'h1234BEEF);
    add(1, 2'd0, 32'h20,       32'h11112222, 4, 1, 4'hF, 0, 0, 32'h1234BEEF);
    add(1, 2'd1, 32'h20,       32'hABCD5678, 4, 1, 4'h3, 0, 0, 32'h1234BEEF);
    add(1, 2'd2, 32'h21,       32'h00000099, 4, 1, 4'h2, 0, 0, 32'h1234BEEF);
    add(1, 2'd1, 32'h21,       32'hFFFFFFFF, 1, 0, 4'h0, 0, 1, 32'h1234BEEF);
    add(0, 2'd0, 32'h20,       32'h0,        4, 1, 4'h0, 0, 0, 32'h11119978);
    add(1, 2'd0, 32'h0,        32'hCAFEF00D, 4, 1, 4'hF, 0, 0, 32'h11119978);
    add(1, 2'd0, 32'h00010000, 32'h55555555, 1, 0, 4'h0, 0, 1, 32'h11119978);
    add(0, 2'd0, 32'h0,        32'h0,        4, 1, 4'h0, 0, 0, 32'hCAFEF00D);
    add(1, 2'd3, 32'h24,       32'h0BADF00D, 4, 1, 4'hF, 0, 0, 32'hCAFEF00D);
    add(0, 2'd1, 32'h24,       32'h0,        4, 1, 4'h0, 0, 0, 32'h0BADF00D);
    add(0, 2'd2, 32'h27,       32'h0,        4, 1, 4'h0, 0, 0, 32'h0BADF00D);
    add(0, 2'd1, 32'h27,       32'h0,        1, 1, 4'h0, 1, 0, 32'h0BADF00D);
    add(0, 2'd0, 32'h4000,     32'h0,        1, 1, 4'h0, 1, 0, 32'h0BADF00D);
    add(1, 2'd0, 32'h30,       32'h12345678, 4, 1, 4'hF, 0, 0, 32'h0BADF00D);

    #12;
    check("reset rdata", rdata, 32'h0);
    check("reset ack", {31'd0, ack}, 32'd0);
    check("reset byte_en", {28'd0, byte_en}, 32'd0);
    check("reset adel/ades", {30'd0, adel, ades}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_acc(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
              lat, stl, be_o, el_o, es_o, rd_o);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d stall cycles", i), stl, vecs[i].lat);
      if (vecs[i].chk_be) check($sformatf("v%0d byte_en", i), {28'd0, be_o}, {28'd0, vecs[i].be});
      check($sformatf("v%0d adel", i), {31'd0, el_o}, {31'd0, vecs[i].el});
      check($sformatf("v%0d ades", i), {31'd0, es_o}, {31'd0, vecs[i].es});
      check($sformatf("v%0d rdata", i), rd_o, vecs[i].rd);
    end

    // req dropped after d edges in WAIT; d=3 drops exactly as the counter hits 0
    for (int d = 1; d <= 3; d++) begin
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h30; wdata = 32'hFFFFFFFF;
      repeat (d) @(posedge clk);
      #1 req = 1'b0;
      acks = 0;
      repeat (6) begin
        @(negedge clk);
        if (ack) acks++;
      end
      check($sformatf("abort d%0d ack count", d), acks, 0);
      check($sformatf("abort d%0d byte_en idle", d), {28'd0, byte_en}, 32'd0);
      run_acc(1'b0, 2'd0, 32'h30, 32'h0, lat, stl, be_o, el_o, es_o, rd_o);
      check($sformatf("abort d%0d reload latency", d), lat, 4);
      check($sformatf("abort d%0d word intact", d), rd_o, 32'h12345678);
    end

    // reset mid-WAIT on a store
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h30; wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midreset ack", {31'd0, ack}, 32'd0);
    check("midreset byte_en", {28'd0, byte_en}, 32'd0);
    check("midreset rdata", rdata, 32'h0);
    req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_acc(1'b0, 2'd0, 32'h30, 32'h0, lat, stl, be_o, el_o, es_o, rd_o);
    check("midreset reload latency", lat, 4);
    check("midreset word intact", rd_o, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
